// File: rtl/uart_receiver.sv
// ---------------------------------------------------------------------------
// uart_receiver
//   8N1 UART receiver. The line is oversampled with the system clock, each
//   bit is sampled at its centre, and every good byte is offered on a
//   ready/valid output register. A bad stop bit and a dropped byte are each
//   reported with a one-cycle pulse.
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous, active-low reset
//   serial_in      asynchronous UART line, idle high
//   data_out       received byte, held while data_out_valid && !data_out_ready
//   data_out_valid a byte is available
//   data_out_ready consumer takes the byte on an edge where valid && ready
//   framing_error  one-cycle pulse: stop bit sampled low
//   overrun        one-cycle pulse: a completed byte was dropped (output full)
// ---------------------------------------------------------------------------
module uart_receiver #(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready,
    output logic       framing_error,
    output logic       overrun
);

    localparam int SYMBOL_EDGE_TIME    = CLOCK_FREQ / BAUD_RATE;
    localparam int SAMPLE_TIME         = SYMBOL_EDGE_TIME / 2;
    localparam int CLOCK_COUNTER_WIDTH = $clog2(SYMBOL_EDGE_TIME);

    localparam logic [CLOCK_COUNTER_WIDTH-1:0] SYMBOL_LAST =
        CLOCK_COUNTER_WIDTH'(SYMBOL_EDGE_TIME - 1);
    localparam logic [CLOCK_COUNTER_WIDTH-1:0] SAMPLE_LAST =
        CLOCK_COUNTER_WIDTH'(SAMPLE_TIME - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t                         state;
    state_t                         state_next;
    logic                           sync_meta;
    logic                           rx;
    logic [CLOCK_COUNTER_WIDTH-1:0] counter;
    logic [2:0]                     bit_index;
    logic [7:0]                     shift_reg;

    // Decoded strobes from the output process
    logic counter_clear;
    logic data_sample;
    logic deliver;
    logic stop_bad;

    // Two-flop synchronizer; preset to the idle level so reset never looks
    // like a start bit.
    // NOTE: all clocked state uses non-blocking assignments so every flop
    // sees the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_meta <= 1'b1;
            rx        <= 1'b1;
        end else begin
            sync_meta <= serial_in;
            rx        <= sync_meta;
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM: next-state logic
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:      if (!rx) state_next = START;
            START:     if (counter == SAMPLE_LAST) state_next = rx ? IDLE : DATA;
            DATA:      if (counter == SYMBOL_LAST && bit_index == 3'd7) state_next = STOP;
            STOP:      if (counter == SYMBOL_LAST) state_next = rx ? IDLE : WAIT_IDLE;
            WAIT_IDLE: if (rx) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // FSM: output decode
    always_comb begin
        data_sample   = 1'b0;
        deliver       = 1'b0;
        stop_bad      = 1'b0;
        counter_clear = (state_next != state) || (counter == SYMBOL_LAST) ||
                        (state == IDLE) || (state == WAIT_IDLE);
        unique case (state)
            DATA:    data_sample = (counter == SYMBOL_LAST);
            STOP: begin
                deliver  = (counter == SYMBOL_LAST) && rx;
                stop_bad = (counter == SYMBOL_LAST) && !rx;
            end
            default: ;
        endcase
    end

    // Bit-period counter, bit index and shift register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            counter   <= '0;
            bit_index <= '0;
            shift_reg <= '0;
        end else begin
            counter <= counter_clear ? '0 : counter + CLOCK_COUNTER_WIDTH'(1);
            if (state == START) begin
                bit_index <= '0;
            end else if (data_sample) begin
                // LSB arrives first, so shifting in at the top leaves bit 0
                // in the LSB after eight samples.
                shift_reg <= {rx, shift_reg[7:1]};
                bit_index <= bit_index + 3'd1;
            end
        end
    end

    // Output register and handshake. A delivery while the consumer is also
    // draining the previous byte replaces it in the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out       <= 8'h00;
            data_out_valid <= 1'b0;
            framing_error  <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            framing_error <= stop_bad;
            overrun       <= 1'b0;
            if (deliver) begin
                if (!data_out_valid || data_out_ready) begin
                    data_out       <= shift_reg;
                    data_out_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (data_out_valid && data_out_ready) begin
                data_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// ---------------------------------------------------------------------------
// tb_uart_receiver
//   Directed bench for uart_receiver. One instance runs at a short bit time
//   (10 clocks per bit), a second at the default 125 MHz / 115200 settings.
//   A negedge monitor logs handshakes and flag pulses; each test task takes
//   the deltas of those logs and compares them with hand-computed values.
// ---------------------------------------------------------------------------
module tb_uart_receiver;

    localparam int BIT_FAST = 10;
    localparam int BIT_DEF  = 1085;
    localparam int LAT_FAST = 2 + 5 + 9 * 10 + 1;        // 98
    localparam int LAT_DEF  = 2 + 542 + 9 * 1085 + 1;    // 10310

    logic       clk;
    logic       reset;
    logic       serial_in;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready;
    logic       framing_error;
    logic       overrun;

    logic       serial_in_d;
    logic [7:0] data_out_d;
    logic       data_out_valid_d;
    logic       data_out_ready_d;
    logic       framing_error_d;
    logic       overrun_d;

    int checks   = 0;
    int failures = 0;

    uart_receiver #(
        .CLOCK_FREQ(1_000_000),
        .BAUD_RATE (100_000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .serial_in     (serial_in),
        .data_out      (data_out),
        .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready),
        .framing_error (framing_error),
        .overrun       (overrun)
    );

    uart_receiver dut_d (
        .clk           (clk),
        .reset         (reset),
        .serial_in     (serial_in_d),
        .data_out      (data_out_d),
        .data_out_valid(data_out_valid_d),
        .data_out_ready(data_out_ready_d),
        .framing_error (framing_error_d),
        .overrun       (overrun_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // Monitor: logs accepted bytes, flag pulses and valid rise times
    logic [7:0] hs_q[$];
    logic [7:0] hs_d_q[$];
    int fe_count = 0, ov_count = 0, vh_count = 0, rise_cycle = 0;
    int fe_d_count = 0, ov_d_count = 0, rise_cycle_d = 0;
    logic valid_q = 1'b0, valid_d_q = 1'b0;

    always @(negedge clk) begin
        if (data_out_valid && data_out_ready) hs_q.push_back(data_out);
        if (framing_error) fe_count++;
        if (overrun) ov_count++;
        if (data_out_valid) vh_count++;
        if (data_out_valid && !valid_q) rise_cycle = cycle;
        valid_q = data_out_valid;
        if (data_out_valid_d && data_out_ready_d) hs_d_q.push_back(data_out_d);
        if (framing_error_d) fe_d_count++;
        if (overrun_d) ov_d_count++;
        if (data_out_valid_d && !valid_d_q) rise_cycle_d = cycle;
        valid_d_q = data_out_valid_d;
    end

    int t_fall = 0;
    int hs_base, fe_base, ov_base, vh_base;

    task automatic snap();
        hs_base = hs_q.size();
        fe_base = fe_count;
        ov_base = ov_count;
        vh_base = vh_count;
    endtask

    task automatic set_line(input int which, input logic v);
        if (which == 0) serial_in = v;
        else            serial_in_d = v;
    endtask

    // Must be entered just after a posedge; returns on the posedge that ends
    // the stop bit, leaving the line at the stop-bit level.
    task automatic send_frame(input int which, input logic [7:0] b,
                              input logic stop_bit, input int bit_cycles);
        #1 set_line(which, 1'b0);
        t_fall = cycle;
        repeat (bit_cycles) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 set_line(which, b[i]);
            repeat (bit_cycles) @(posedge clk);
        end
        #1 set_line(which, stop_bit);
        repeat (bit_cycles) @(posedge clk);
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        serial_in      = 1'b1;
        serial_in_d    = 1'b1;
        data_out_ready = 1'b1;
        data_out_ready_d = 1'b1;
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (data_out !== 8'h00) begin
            failures++; $display("FAIL reset_data: got %h expected 00", data_out);
        end
        checks++;
        if (data_out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_valid: got %b expected 0", data_out_valid);
        end
        checks++;
        if (framing_error !== 1'b0 || overrun !== 1'b0) begin
            failures++; $display("FAIL reset_flags: got fe=%b ov=%b expected 0 0", framing_error, overrun);
        end
        checks++;
        if (data_out_valid_d !== 1'b0 || data_out_d !== 8'h00) begin
            failures++; $display("FAIL reset_default_inst: got v=%b d=%h expected 0 00", data_out_valid_d, data_out_d);
        end
        reset = 1'b1;
        repeat (5) @(posedge clk);
    endtask

    task automatic test_single_frame();
        snap();
        @(posedge clk);
        send_frame(0, 8'hA5, 1'b1, BIT_FAST);
        repeat (5) @(posedge clk);
        #1;
        check_int("single_count", hs_q.size() - hs_base, 1);
        if (hs_q.size() > hs_base) begin
            checks++;
            if (hs_q[hs_base] !== 8'hA5) begin
                failures++; $display("FAIL single_data: got %h expected a5", hs_q[hs_base]);
            end
        end
        checks++;
        if (rise_cycle - t_fall < LAT_FAST - 2 || rise_cycle - t_fall > LAT_FAST + 2) begin
            failures++; $display("FAIL single_latency: got %0d expected %0d+-2", rise_cycle - t_fall, LAT_FAST);
        end
        check_int("single_valid_cycles", vh_count - vh_base, 1);
        check_int("single_valid_low", int'(data_out_valid), 0);
        check_int("single_flags", (fe_count - fe_base) + (ov_count - ov_base), 0);
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_bytes[3];
        exp_bytes = '{8'h00, 8'hFF, 8'h3C};
        snap();
        @(posedge clk);
        for (int i = 0; i < 3; i++) send_frame(0, exp_bytes[i], 1'b1, BIT_FAST);
        repeat (5) @(posedge clk);
        check_int("b2b_count", hs_q.size() - hs_base, 3);
        for (int i = 0; i < 3; i++) begin
            if (hs_q.size() > hs_base + i) begin
                checks++;
                if (hs_q[hs_base + i] !== exp_bytes[i]) begin
                    failures++;
                    $display("FAIL b2b_data[%0d]: got %h expected %h", i, hs_q[hs_base + i], exp_bytes[i]);
                end
            end
        end
        check_int("b2b_flags", (fe_count - fe_base) + (ov_count - ov_base), 0);
    endtask

    task automatic test_glitch();
        snap();
        @(posedge clk);
        #1 serial_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 serial_in = 1'b1;
        repeat (20) @(posedge clk);
        check_int("glitch_no_valid", vh_count - vh_base, 0);
        check_int("glitch_flags", (fe_count - fe_base) + (ov_count - ov_base), 0);
        send_frame(0, 8'h5A, 1'b1, BIT_FAST);
        repeat (5) @(posedge clk);
        check_int("glitch_next_count", hs_q.size() - hs_base, 1);
        if (hs_q.size() > hs_base) begin
            checks++;
            if (hs_q[hs_base] !== 8'h5A) begin
                failures++; $display("FAIL glitch_next_data: got %h expected 5a", hs_q[hs_base]);
            end
        end
    endtask

    task automatic test_framing_error();
        snap();
        @(posedge clk);
        send_frame(0, 8'h81, 1'b0, BIT_FAST);
        repeat (30) @(posedge clk);
        #1 serial_in = 1'b1;
        repeat (20) @(posedge clk);
        check_int("fe_pulses", fe_count - fe_base, 1);
        check_int("fe_no_valid", vh_count - vh_base, 0);
        send_frame(0, 8'h42, 1'b1, BIT_FAST);
        repeat (5) @(posedge clk);
        check_int("fe_next_count", hs_q.size() - hs_base, 1);
        if (hs_q.size() > hs_base) begin
            checks++;
            if (hs_q[hs_base] !== 8'h42) begin
                failures++; $display("FAIL fe_next_data: got %h expected 42", hs_q[hs_base]);
            end
        end
        check_int("fe_pulses_after", fe_count - fe_base, 1);
    endtask

    task automatic test_overrun();
        snap();
        @(posedge clk);
        #1 data_out_ready = 1'b0;
        @(posedge clk);
        send_frame(0, 8'h11, 1'b1, BIT_FAST);
        send_frame(0, 8'h22, 1'b1, BIT_FAST);
        repeat (5) @(posedge clk);
        #1;
        check_int("ovr_valid_held", int'(data_out_valid), 1);
        checks++;
        if (data_out !== 8'h11) begin
            failures++; $display("FAIL ovr_data_held: got %h expected 11", data_out);
        end
        check_int("ovr_pulses", ov_count - ov_base, 1);
        check_int("ovr_no_handshake", hs_q.size() - hs_base, 0);
        @(posedge clk);
        #1 data_out_ready = 1'b1;
        @(posedge clk);
        #1 data_out_ready = 1'b0;
        @(negedge clk);
        check_int("ovr_valid_dropped", int'(data_out_valid), 0);
        check_int("ovr_drain_count", hs_q.size() - hs_base, 1);
        if (hs_q.size() > hs_base) begin
            checks++;
            if (hs_q[hs_base] !== 8'h11) begin
                failures++; $display("FAIL ovr_drain_data: got %h expected 11", hs_q[hs_base]);
            end
        end
        check_int("ovr_fe", fe_count - fe_base, 0);
        @(posedge clk);
        #1 data_out_ready = 1'b1;
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        b = 8'h99;
        // Park a byte in the output register so reset has something to clear
        @(posedge clk);
        #1 data_out_ready = 1'b0;
        @(posedge clk);
        send_frame(0, 8'h77, 1'b1, BIT_FAST);
        repeat (3) @(posedge clk);
        check_int("rst_pre_valid", int'(data_out_valid), 1);
        // Start 0x99 and abort it three bits into DATA
        #1 serial_in = 1'b0;
        repeat (BIT_FAST) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            #1 serial_in = b[i];
            repeat (BIT_FAST) @(posedge clk);
        end
        #3 reset = 1'b0;
        #1;
        checks++;
        if (data_out !== 8'h00 || data_out_valid !== 1'b0) begin
            failures++; $display("FAIL rst_async_clear: got d=%h v=%b expected 00 0", data_out, data_out_valid);
        end
        serial_in = 1'b1;
        snap();
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (data_out !== 8'h00 || data_out_valid !== 1'b0 || framing_error !== 1'b0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL rst_held: got d=%h v=%b fe=%b ov=%b expected 00 0 0 0",
                     data_out, data_out_valid, framing_error, overrun);
        end
        reset = 1'b1;
        data_out_ready = 1'b1;
        repeat (20) @(posedge clk);
        send_frame(0, 8'h66, 1'b1, BIT_FAST);
        repeat (5) @(posedge clk);
        check_int("rst_next_count", hs_q.size() - hs_base, 1);
        if (hs_q.size() > hs_base) begin
            checks++;
            if (hs_q[hs_base] !== 8'h66) begin
                failures++; $display("FAIL rst_next_data: got %h expected 66", hs_q[hs_base]);
            end
        end
        check_int("rst_flags", (fe_count - fe_base) + (ov_count - ov_base), 0);
    endtask

    task automatic test_default_baud();
        int base;
        base = hs_d_q.size();
        @(posedge clk);
        send_frame(1, 8'hA5, 1'b1, BIT_DEF);
        repeat (5) @(posedge clk);
        check_int("def_count", hs_d_q.size() - base, 1);
        if (hs_d_q.size() > base) begin
            checks++;
            if (hs_d_q[base] !== 8'hA5) begin
                failures++; $display("FAIL def_data: got %h expected a5", hs_d_q[base]);
            end
        end
        checks++;
        if (rise_cycle_d - t_fall < LAT_DEF - 1 || rise_cycle_d - t_fall > LAT_DEF + 1) begin
            failures++; $display("FAIL def_latency: got %0d expected %0d+-1", rise_cycle_d - t_fall, LAT_DEF);
        end
        check_int("def_flags", fe_d_count + ov_d_count, 0);
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_glitch();
        test_framing_error();
        test_overrun();
        test_reset_mid_frame();
        test_default_baud();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
Serial-to-parallel UART receiver that pairs with the lab UART transmitter. It uses the 8N1 framing: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), with the line idle high. It oversamples `serial_in` with the system clock, samples each bit at its centre, and presents each received byte on a ready/valid interface to downstream logic such as a FIFO or the lab's command parser. It flags framing errors and overruns.

Parameters:
- CLOCK_FREQ, 125_000_000, system clock frequency in Hz.
- BAUD_RATE, 115_200, line rate in bits/s.
- Derived localparams:
  - SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE; 1085 at the defaults.
  - SAMPLE_TIME = SYMBOL_EDGE_TIME / 2; 542 at the defaults.
  - CLOCK_COUNTER_WIDTH = $clog2(SYMBOL_EDGE_TIME).

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- serial_in  input  1  asynchronous UART line, idle high.
- data_out  output  8  received byte; stable while data_out_valid is high.
- data_out_valid  output  1  byte available.
- data_out_ready  input  1  consumer accepts the byte when both valid and ready are high on a clk edge.
- framing_error  output  1  one-cycle pulse: stop bit sampled as 0.
- overrun  output  1  one-cycle pulse: a completed byte was dropped because the output register was full.

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE; counters = 0.
  - data_out = 8'h00, data_out_valid = 0, framing_error = 0, overrun = 0.
  - Synchronizer flops preset to 1.
- Input synchronizer: serial_in passes through 2 flops. All decisions use the synchronized bit (rx). This gives 2 cycles of input latency.
- Clock counter: counts 0..SYMBOL_EDGE_TIME-1. It clears on every state transition and when a bit period expires.
- FSM states and transitions:
  - IDLE: when rx == 0, go to START and clear the counter.
  - START: at counter == SAMPLE_TIME-1, sample rx.
    - rx == 1: glitch; return to IDLE with no flags.
    - rx == 0: go to DATA, clear the counter, bit index = 0.
  - DATA: at each counter == SYMBOL_EDGE_TIME-1 (the mid-bit point), shift rx into the MSB of the shift register. This makes bit 0 end up in the LSB. Increment the bit index. After the 8th sample, go to STOP.
  - STOP: at counter == SYMBOL_EDGE_TIME-1, sample rx.
    - rx == 1: deliver the byte (see output handshake); go to IDLE. No wait for the end of the stop bit, so back-to-back frames resynchronise on the next falling edge.
    - rx == 0: pulse framing_error for 1 cycle, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx == 1, then go to IDLE. A break or held-low line therefore produces exactly one framing_error and no spurious frames.
- Output handshake (evaluated on the delivery cycle, the cycle after the STOP sample):
  - valid == 0: load data_out, set valid = 1.
  - valid == 1 and ready == 1: handshake completes and the new byte loads in the same edge; valid stays 1.
  - valid == 1 and ready == 0: keep the old byte, drop the new one, pulse overrun for 1 cycle.
  - Outside delivery, valid clears on the edge where valid && ready. data_out does not change while valid == 1 and ready == 0.
- Latency: data_out_valid rises 2 + SAMPLE_TIME + 9*SYMBOL_EDGE_TIME + 1 cycles (±1) after the serial_in falling edge of the start bit.
- Reset mid-frame: abort immediately. After release, the FSM waits in IDLE. A low line at release is taken as a start bit, and its START check rejects it if the line is actually high.
- Baud rates producing SYMBOL_EDGE_TIME < 4 are unsupported.

Test Plan:
All scenarios use CLOCK_FREQ=1_000_000 and BAUD_RATE=100_000 (SYMBOL_EDGE_TIME=10, SAMPLE_TIME=5) unless noted; data_out_ready is held at 1 unless noted.
1. Send 0xA5 as one frame -> data_out = 8'hA5, data_out_valid high within 98±2 cycles of the start edge, then low 1 cycle later; framing_error = overrun = 0.
2. Send 0x00, 0xFF, 0x3C back-to-back with no idle gap -> exactly three valid handshakes in order 00, FF, 3C; no flags.
3. Low glitch of 3 cycles on the idle line -> no valid and no flags; FSM back in IDLE; a following frame 0x5A is received correctly.
4. Frame 0x81 with the stop bit forced to 0, line then held low for 30 cycles -> one framing_error pulse, no valid. After the line returns high, the next frame 0x42 is received.
5. data_out_ready = 0, send 0x11 then 0x22 -> valid held with data_out = 11; overrun pulses once at 0x22 delivery. Raising ready for 1 cycle drains 11; valid then drops.
6. Assert reset mid-DATA of frame 0x99, release, then send 0x66 -> all outputs 0 during reset; only 0x66 is delivered; no flags. Repeat at the default parameters with 0xA5 to confirm the 1085-cycle bit timing.
